// File: rtl/module_dispatch_pkg.sv
// module_dispatch_pkg: shared selector codes, dispatch state encoding and widths
package module_dispatch_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        MUX_TRAVERSAL,
        MUX_EXECUTE,
        MUX_CELL,
        MUX_INCR,
        MUX_EQUAL,
        MUX_EDIT
    } mux_sel_t;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_START,
        DISP_WAIT,
        DISP_RESP
    } disp_state_t;

    localparam logic [3:0] DISP_RET_TMO = 4'hF;

    // Slot 0 is traversal itself and anything past the last slot has no module.
    function automatic logic sel_ok(input int s, input int n);
        return (s != int'(MUX_TRAVERSAL)) && (s < n);
    endfunction

endpackage

// File: rtl/module_dispatch_timer.sv
// dispatch_timer: watchdog counter bounding how long dispatch waits for a module
module dispatch_timer
    import module_dispatch_pkg::*;
#(
    parameter int          TMO_W     = 16,
    parameter int unsigned TMO_LIMIT = 32'hFFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_LIMIT - 1);

    logic [TMO_W-1:0] r_count;

    // Count enabled wait cycles; cleared whenever a new dispatch starts.
    always_ff @(posedge clk) begin
        if (rst || clr) r_count <= '0;
        else if (en) r_count <= r_count + 1'b1;
    end

    // Flags the wait cycle whose increment brings the count up to the limit.
    assign expired = (TMO_LIMIT != 0) && en && (r_count == LAST);

endmodule

// File: rtl/module_dispatch.sv
// module_dispatch: registered request dispatcher between traversal and the operation modules
module module_dispatch
    import module_dispatch_pkg::*;
#(
    parameter int          N_MOD     = 6,
    parameter int          SEL_W     = 3,
    parameter int          ADDR_W    = MEM_ADDR_W,
    parameter int          DATA_W    = MEM_DATA_W,
    parameter int          TMO_W     = 16,
    parameter int unsigned TMO_LIMIT = 32'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [SEL_W-1:0]         sel,
    input  logic [ADDR_W-1:0]        module_address,
    input  logic [DATA_W-1:0]        module_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [3:0]               return_sys_func,
    output logic [3:0]               return_state,
    output logic [N_MOD-1:0]         mod_start,
    output logic [N_MOD*ADDR_W-1:0]  mod_address,
    output logic [N_MOD*DATA_W-1:0]  mod_data,
    input  logic [N_MOD-1:0]         mod_finished,
    input  logic [N_MOD*4-1:0]       mod_return_sys_func,
    input  logic [N_MOD*4-1:0]       mod_return_state
);

    disp_state_t        r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [3:0]         r_ret_func;
    logic [3:0]         r_ret_state;
    logic [N_MOD-1:0]   r_start;
    logic               w_fin;
    logic [3:0]         w_fin_func;
    logic [3:0]         w_fin_state;
    logic               w_tmo;

    // Pick out only the selected slot's finished flag and return values.
    always_comb begin
        w_fin       = 1'b0;
        w_fin_func  = '0;
        w_fin_state = '0;
        for (int i = 0; i < N_MOD; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_fin       = mod_finished[i];
                w_fin_func  = mod_return_sys_func[i*4 +: 4];
                w_fin_state = mod_return_state[i*4 +: 4];
            end
        end
    end

    dispatch_timer #(
        .TMO_W    (TMO_W),
        .TMO_LIMIT(TMO_LIMIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (r_state == DISP_START),
        .en     ((r_state == DISP_WAIT) && !w_fin),
        .expired(w_tmo)
    );

    // Route the captured address/data to the selected slot while a request is in flight.
    always_comb begin
        mod_address = '0;
        mod_data    = '0;
        for (int i = 0; i < N_MOD; i++) begin
            if ((r_state != DISP_IDLE) && (r_sel == SEL_W'(i))) begin
                mod_address[i*ADDR_W +: ADDR_W] = r_addr;
                mod_data[i*DATA_W +: DATA_W]    = r_data;
            end
        end
    end

    // Dispatch FSM with registered busy/done/err/start and latched return fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DISP_IDLE;
            r_sel       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ret_func  <= '0;
            r_ret_state <= '0;
            r_start     <= '0;
        end else begin
            r_done  <= 1'b0;
            r_start <= '0;
            case (r_state)
                DISP_IDLE: begin
                    if (req) begin
                        r_sel  <= sel;
                        r_addr <= module_address;
                        r_data <= module_data;
                        r_busy <= 1'b1;
                        if (sel_ok(int'(sel), N_MOD)) begin
                            r_start <= N_MOD'(1) << sel;
                            r_state <= DISP_START;
                        end else begin
                            r_ret_func  <= '0;
                            r_ret_state <= '0;
                            r_done      <= 1'b1;
                            r_err       <= 1'b1;
                            r_state     <= DISP_RESP;
                        end
                    end
                end
                DISP_START: r_state <= DISP_WAIT;
                DISP_WAIT: begin
                    if (w_fin) begin
                        r_ret_func  <= w_fin_func;
                        r_ret_state <= w_fin_state;
                        r_done      <= 1'b1;
                        r_err       <= 1'b0;
                        r_state     <= DISP_RESP;
                    end else if (w_tmo) begin
                        r_ret_func  <= DISP_RET_TMO;
                        r_ret_state <= DISP_RET_TMO;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                        r_state     <= DISP_RESP;
                    end
                end
                DISP_RESP: begin
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= DISP_IDLE;
                end
                default: r_state <= DISP_IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign return_sys_func = r_ret_func;
    assign return_state    = r_ret_state;
    assign mod_start       = r_start;

endmodule

// File: tb/tb_module_dispatch.sv
// tb_module_dispatch: directed scoreboard bench for module_dispatch
module tb_module_dispatch;

    localparam int N_MOD  = 6;
    localparam int SEL_W  = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic       err;
        logic [3:0] func;
        logic [3:0] state;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    req = 1'b0;
    logic [SEL_W-1:0]        sel = '0;
    logic [ADDR_W-1:0]       module_address = '0;
    logic [DATA_W-1:0]       module_data = '0;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [3:0]              return_sys_func;
    logic [3:0]              return_state;
    logic [N_MOD-1:0]        mod_start;
    logic [N_MOD*ADDR_W-1:0] mod_address;
    logic [N_MOD*DATA_W-1:0] mod_data;
    logic [N_MOD-1:0]        mod_finished = '0;
    logic [N_MOD*4-1:0]      mod_return_sys_func = '0;
    logic [N_MOD*4-1:0]      mod_return_state = '0;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat;

    module_dispatch #(
        .N_MOD    (N_MOD),
        .SEL_W    (SEL_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TMO_W    (16),
        .TMO_LIMIT(8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .sel                (sel),
        .module_address     (module_address),
        .module_data        (module_data),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .return_sys_func    (return_sys_func),
        .return_state       (return_state),
        .mod_start          (mod_start),
        .mod_address        (mod_address),
        .mod_data           (mod_data),
        .mod_finished       (mod_finished),
        .mod_return_sys_func(mod_return_sys_func),
        .mod_return_state   (mod_return_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget, output int l);
        exp_t e;
        l = 0;
        while (done !== 1'b1 && l < budget) begin
            step();
            l++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_queued"}, q.size() > 0, 1);
        if (done === 1'b1 && q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_err"}, err, e.err);
            check({tag, "_func"}, return_sys_func, e.func);
            check({tag, "_state"}, return_state, e.state);
        end
    endtask

    task automatic issue(input logic [SEL_W-1:0] s, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req = 1'b1;
        sel = s;
        module_address = a;
        module_data = d;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_func", return_sys_func, 0);
        check("rst_state", return_state, 0);
        check("rst_start", mod_start, 0);
        check("rst_addr", mod_address, 0);
        check("rst_data", mod_data, 0);

        // Normal dispatch to the cell slot
        issue(3'd2, 16'h0010, 32'h0000ABCD);
        q.push_back('{err: 1'b0, func: 4'd3, state: 4'd5});
        step();
        req = 1'b0;
        check("norm_start", mod_start, 6'b000100);
        check("norm_busy", busy, 1);
        check("norm_addr2", mod_address[2*ADDR_W +: ADDR_W], 16'h0010);
        check("norm_data2", mod_data[2*DATA_W +: DATA_W], 32'h0000ABCD);
        check("norm_addr3", mod_address[3*ADDR_W +: ADDR_W], 0);
        step();
        check("norm_start_pulse", mod_start, 0);
        step();
        step();
        check("norm_no_early_done", done, 0);
        mod_finished[2] = 1'b1;
        mod_return_sys_func[2*4 +: 4] = 4'd3;
        mod_return_state[2*4 +: 4] = 4'd5;
        wait_done("norm", 4, lat);
        check("norm_lat", lat, 1);
        mod_finished[2] = 1'b0;
        step();
        check("norm_done_pulse", done, 0);
        check("norm_idle_busy", busy, 0);
        check("norm_hold_func", return_sys_func, 3);
        check("norm_idle_addr", mod_address, 0);

        // Bad selectors: slot 0 and beyond the last slot
        issue(3'd0, 16'h1234, 32'h1);
        q.push_back('{err: 1'b1, func: 4'd0, state: 4'd0});
        step();
        req = 1'b0;
        check("bad0_start", mod_start, 0);
        wait_done("bad0", 3, lat);
        check("bad0_lat", lat, 0);
        step();
        issue(3'd7, 16'h5678, 32'h2);
        q.push_back('{err: 1'b1, func: 4'd0, state: 4'd0});
        step();
        req = 1'b0;
        check("bad7_start", mod_start, 0);
        wait_done("bad7", 3, lat);
        check("bad7_lat", lat, 0);
        step();
        check("bad7_idle", busy, 0);

        // Timeout: slot 4 never finishes
        issue(3'd4, 16'h0044, 32'h44);
        q.push_back('{err: 1'b1, func: 4'hF, state: 4'hF});
        step();
        req = 1'b0;
        check("tmo_start", mod_start, 6'b010000);
        check("tmo_busy", busy, 1);
        wait_done("tmo", 20, lat);
        check("tmo_lat", lat, 9);
        check("tmo_busy_resp", busy, 1);
        step();
        check("tmo_busy_end", busy, 0);

        // Cross-talk: slot 3 finishes while slot 1 is pending
        issue(3'd1, 16'h0011, 32'h11);
        q.push_back('{err: 1'b0, func: 4'd1, state: 4'd2});
        step();
        req = 1'b0;
        mod_finished[3] = 1'b1;
        mod_return_sys_func[3*4 +: 4] = 4'd9;
        mod_return_state[3*4 +: 4] = 4'd9;
        step();
        step();
        step();
        check("xt_no_done", done, 0);
        check("xt_busy", busy, 1);
        mod_finished[1] = 1'b1;
        mod_return_sys_func[1*4 +: 4] = 4'd1;
        mod_return_state[1*4 +: 4] = 4'd2;
        wait_done("xt", 4, lat);
        check("xt_lat", lat, 1);
        mod_finished[1] = 1'b0;
        mod_finished[3] = 1'b0;
        step();

        // Reset during WAIT, then a normal request
        issue(3'd5, 16'h0055, 32'h55);
        step();
        req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err, 0);
        check("mrst_func", return_sys_func, 0);
        check("mrst_state", return_state, 0);
        check("mrst_start", mod_start, 0);
        check("mrst_addr", mod_address, 0);
        check("mrst_data", mod_data, 0);
        step();
        step();
        check("mrst_no_done", done, 0);
        mod_finished[5] = 1'b1;
        mod_return_sys_func[5*4 +: 4] = 4'd7;
        mod_return_state[5*4 +: 4] = 4'd1;
        issue(3'd5, 16'h0056, 32'h56);
        q.push_back('{err: 1'b0, func: 4'd7, state: 4'd1});
        step();
        req = 1'b0;
        check("mrst_start2", mod_start, 6'b100000);
        wait_done("mrst", 4, lat);
        check("mrst_lat", lat, 2);
        mod_finished[5] = 1'b0;
        step();

        // Back-to-back with req held high
        mod_finished[3] = 1'b1;
        mod_return_sys_func[3*4 +: 4] = 4'd4;
        mod_return_state[3*4 +: 4] = 4'd6;
        issue(3'd3, 16'h0033, 32'h33);
        q.push_back('{err: 1'b0, func: 4'd4, state: 4'd6});
        step();
        check("b2b_start1", mod_start, 6'b001000);
        wait_done("b2b1", 4, lat);
        check("b2b1_lat", lat, 2);
        mod_return_sys_func[3*4 +: 4] = 4'd8;
        mod_return_state[3*4 +: 4] = 4'd2;
        q.push_back('{err: 1'b0, func: 4'd8, state: 4'd2});
        step();
        check("b2b_idle_busy", busy, 0);
        check("b2b_idle_start", mod_start, 0);
        step();
        req = 1'b0;
        check("b2b_start2", mod_start, 6'b001000);
        wait_done("b2b2", 4, lat);
        check("b2b2_lat", lat, 2);
        mod_finished[3] = 1'b0;
        step();
        check("b2b_end_busy", busy, 0);
        check("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
